// File: rtl/pillar_bus_pkg.sv
// Shared bus types and widths for the memory-side responder and its SRAM.
package pillar_bus_pkg;

  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } resp_state_t;

  // Word-index width; floor of 1 keeps degenerate depths from producing zero-width vectors.
  function automatic int word_idx_w(input int depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

endpackage

// File: rtl/resp_sram.sv
// Single-port word array with per-byte write enable and a registered read port.
module resp_sram
  import pillar_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IW          = word_idx_w(DEPTH_WORDS)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [BUS_BEW-1:0] be_i,
  input  logic [IW-1:0]      idx_i,
  input  logic [BUS_DW-1:0]  wdata_i,
  output logic [BUS_DW-1:0]  rdata_o
);

  logic [BUS_DW-1:0] mem_q [DEPTH_WORDS];
  logic [BUS_DW-1:0] rdata_q;

  // The array is deliberately not reset; contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < BUS_BEW; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_responder.sv
// Memory-side bus responder: one request at a time, fixed wait, SRAM-backed, error on bad address.
// Optional statistics counters are enabled with the BUS_RESPONDER_STATS_EN macro.
module bus_responder
  import pillar_bus_pkg::*;
#(
  parameter int                DEPTH_WORDS = 1024,
  parameter int                LATENCY     = 2,
  parameter logic [BUS_AW-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [BUS_AW-1:0]  addr_i,
  input  logic [BUS_BEW-1:0] be_i,
  input  logic [BUS_DW-1:0]  wdata_i,
  output logic [BUS_DW-1:0]  rdata_o,
  output logic               ack_o,
  output logic               err_o,
  output resp_state_t        state_o
`ifdef BUS_RESPONDER_STATS_EN
  ,
  output logic [31:0]        rd_count_o,
  output logic [31:0]        wr_count_o,
  output logic [15:0]        err_count_o
`endif
);

  // Handshake: the initiator raises req_i with stable fields and holds them until ack_o; a
  // request is accepted on the first edge in IDLE with req_i=1, and ack_o pulses exactly once
  // (with err_o qualifying it). req_i is ignored in WAIT and ACK.

  localparam int          IW   = word_idx_w(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT4 = 4'(LATENCY);

  resp_state_t        state_q;
  logic [3:0]         cnt_q;
  logic               we_q;
  logic [BUS_BEW-1:0] be_q;
  logic [BUS_DW-1:0]  wdata_q;
  logic [IW-1:0]      idx_q;
  logic               bad_q;
  logic               ack_q;
  logic               err_q;
  logic               rd_valid_q;

  // 33-bit offset: a borrow out of bit 32 means the address is below BASE_ADDR, so no wrap-around.
  logic [32:0]        off;
  logic               in_range;
  logic               bad_in;
  logic [IW-1:0]      idx_in;

  assign off      = {1'b0, addr_i} - {1'b0, BASE_ADDR};
  assign in_range = !off[32] && (off < SPAN);
  assign bad_in   = !in_range || (addr_i[1:0] != 2'b00);
  assign idx_in   = off[IW+1:2];

  // With LATENCY=0 the SRAM access happens on the accepting edge, so it must see the live inputs.
  logic               go_ack;
  logic               cur_we;
  logic [BUS_BEW-1:0] cur_be;
  logic [BUS_DW-1:0]  cur_wdata;
  logic [IW-1:0]      cur_idx;
  logic               cur_bad;
  logic               sram_we;
  logic               sram_re;
  logic [BUS_DW-1:0]  sram_rdata;

  always_comb begin
    go_ack    = 1'b0;
    cur_we    = we_q;
    cur_be    = be_q;
    cur_wdata = wdata_q;
    cur_idx   = idx_q;
    cur_bad   = bad_q;
    case (state_q)
      IDLE: begin
        go_ack    = req_i && (LATENCY == 0);
        cur_we    = we_i;
        cur_be    = be_i;
        cur_wdata = wdata_i;
        cur_idx   = idx_in;
        cur_bad   = bad_in;
      end
      WAIT:    go_ack = (cnt_q == 4'd1);
      default: go_ack = 1'b0;
    endcase
  end

  assign sram_we = go_ack && cur_we && !cur_bad;
  assign sram_re = go_ack && !cur_we && !cur_bad;

  resp_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IW          (IW)
  ) u_sram (
    .clk     (clk),
    .we_i    (sram_we),
    .re_i    (sram_re),
    .be_i    (cur_be),
    .idx_i   (cur_idx),
    .wdata_i (cur_wdata),
    .rdata_o (sram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      bad_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      ack_q      <= go_ack;
      err_q      <= go_ack && cur_bad;
      rd_valid_q <= sram_re;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            be_q    <= be_i;
            wdata_q <= wdata_i;
            idx_q   <= idx_in;
            bad_q   <= bad_in;
            cnt_q   <= LAT4;
            state_q <= (LATENCY == 0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ACK;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rd_valid_q ? sram_rdata : '0;
  assign state_o = state_q;

`ifdef BUS_RESPONDER_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;
  logic [15:0] err_cnt_q;

  // Holding registers are still valid during ACK, so they classify the completing access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (ack_q) begin
      if (err_q) begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (we_q) begin
        if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 32'd1;
      end else begin
        if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 32'd1;
      end
    end
  end

  assign rd_count_o  = rd_cnt_q;
  assign wr_count_o  = wr_cnt_q;
  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: three instances with LATENCY 0, 3 and 2 (index 0, 1, 2).
module tb_bus_responder;
  import pillar_bus_pkg::*;

  logic             clk;
  logic             rst;
  logic [2:0]       req;
  logic [2:0]       we;
  logic [2:0][31:0] addr;
  logic [2:0][3:0]  be;
  logic [2:0][31:0] wdata;
  logic [2:0][31:0] rdata;
  logic [2:0]       ack;
  logic [2:0]       err;
  resp_state_t [2:0] st;
`ifdef BUS_RESPONDER_STATS_EN
  logic [2:0][31:0] rdc;
  logic [2:0][31:0] wrc;
  logic [2:0][15:0] erc;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  bus_responder #(.DEPTH_WORDS(1024), .LATENCY(0), .BASE_ADDR(32'h0)) u_l0 (
    .clk(clk), .reset(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]), .be_i(be[0]),
    .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ack_o(ack[0]), .err_o(err[0]), .state_o(st[0])
`ifdef BUS_RESPONDER_STATS_EN
    , .rd_count_o(rdc[0]), .wr_count_o(wrc[0]), .err_count_o(erc[0])
`endif
  );

  bus_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .BASE_ADDR(32'h0)) u_l3 (
    .clk(clk), .reset(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]), .be_i(be[1]),
    .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ack_o(ack[1]), .err_o(err[1]), .state_o(st[1])
`ifdef BUS_RESPONDER_STATS_EN
    , .rd_count_o(rdc[1]), .wr_count_o(wrc[1]), .err_count_o(erc[1])
`endif
  );

  bus_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) u_l2 (
    .clk(clk), .reset(rst), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]), .be_i(be[2]),
    .wdata_i(wdata[2]), .rdata_o(rdata[2]), .ack_o(ack[2]), .err_o(err[2]), .state_o(st[2])
`ifdef BUS_RESPONDER_STATS_EN
    , .rd_count_o(rdc[2]), .wr_count_o(wrc[2]), .err_count_o(erc[2])
`endif
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // lat = number of negedges after the accepting edge until ack_o is seen (LATENCY+1).
  task automatic do_txn(input int u, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] rd, output logic e,
                        output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    rd   = '0;
    e    = 1'b0;
    @(negedge clk);
    req[u] = 1'b1; we[u] = w; addr[u] = a; be[u] = b; wdata[u] = d;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (ack[u]) begin
        seen   = 1'b1;
        lat    = c;
        rd     = rdata[u];
        e      = err[u];
        req[u] = 1'b0;
      end
    end
    req[u] = 1'b0;
    chk("ack_seen", {31'b0, seen}, 32'd1);
    @(negedge clk);
    chk("ack_one_cycle", {31'b0, ack[u]}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  int          tack [2];
  logic [31:0] tdat [2];
  int          nack;
  int          acks_seen;

  initial begin
    rst = 1'b0; req = '0; we = '0; addr = '0; be = '0; wdata = '0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("rst_ack",   {31'b0, ack[u]}, 32'd0);
      chk("rst_err",   {31'b0, err[u]}, 32'd0);
      chk("rst_rdata", rdata[u], 32'd0);
      chk("rst_state", {30'b0, st[u]}, {30'b0, IDLE});
    end
    rst = 1'b1;
    @(negedge clk);

    // 1: basic write/read, LATENCY=2 -> ack in cycle t+3
    do_txn(2, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, rd, e, lat);
    chk("wr10_lat", lat, 32'd3);
    chk("wr10_err", {31'b0, e}, 32'd0);
    do_txn(2, 1'b0, 32'h10, 4'h0, 32'h0, rd, e, lat);
    chk("rd10_data", rd, 32'hDEAD_BEEF);
    chk("rd10_err", {31'b0, e}, 32'd0);
    chk("rd10_lat", lat, 32'd3);

    // 2: byte enables
    do_txn(2, 1'b1, 32'h20, 4'hF, 32'h1122_3344, rd, e, lat);
    do_txn(2, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, rd, e, lat);
    do_txn(2, 1'b0, 32'h20, 4'h0, 32'h0, rd, e, lat);
    chk("rd20_be0101", rd, 32'h11BB_33DD);
    do_txn(2, 1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF, rd, e, lat);
    chk("wr20_be0_err", {31'b0, e}, 32'd0);
    do_txn(2, 1'b0, 32'h20, 4'h0, 32'h0, rd, e, lat);
    chk("rd20_be0", rd, 32'h11BB_33DD);

    // 3: errors
    do_txn(2, 1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, rd, e, lat);
    do_txn(2, 1'b0, 32'h22, 4'h0, 32'h0, rd, e, lat);
    chk("rd22_err", {31'b0, e}, 32'd1);
    chk("rd22_rdata", rd, 32'd0);
    chk("rd22_lat", lat, 32'd3);
    do_txn(2, 1'b1, 32'h1000, 4'hF, 32'h1234_5678, rd, e, lat);
    chk("wr1000_err", {31'b0, e}, 32'd1);
    do_txn(2, 1'b0, 32'h0, 4'h0, 32'h0, rd, e, lat);
    chk("rd0_after_err", rd, 32'hCAFE_F00D);
    chk("rd0_err", {31'b0, e}, 32'd0);
    do_txn(2, 1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0, rd, e, lat);
    chk("rdFFFC_err", {31'b0, e}, 32'd1);
    chk("rdFFFC_rdata", rd, 32'd0);
    do_txn(2, 1'b1, 32'hFFC, 4'hF, 32'h0BAD_CAFE, rd, e, lat);
    chk("wrFFC_err", {31'b0, e}, 32'd0);
    do_txn(2, 1'b0, 32'hFFC, 4'h0, 32'h0, rd, e, lat);
    chk("rdFFC_data", rd, 32'h0BAD_CAFE);

    // 4a: LATENCY=0, back-to-back reads with req held -> acks two cycles apart
    do_txn(0, 1'b1, 32'h0, 4'hF, 32'hA0A0_A0A0, rd, e, lat);
    chk("l0_wr_lat", lat, 32'd1);
    do_txn(0, 1'b1, 32'h4, 4'hF, 32'hB1B1_B1B1, rd, e, lat);
    nack = 0;
    tack[0] = 0; tack[1] = 0; tdat[0] = '0; tdat[1] = '0;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0; be[0] = 4'h0;
    for (int c = 1; c <= 20 && nack < 2; c++) begin
      @(negedge clk);
      if (ack[0]) begin
        tack[nack] = c;
        tdat[nack] = rdata[0];
        nack++;
        addr[0] = 32'h4;
      end
    end
    req[0] = 1'b0;
    chk("b2b_nack", nack, 32'd2);
    chk("b2b_ack0_cycle", tack[0], 32'd1);
    chk("b2b_ack1_cycle", tack[1], 32'd3);
    chk("b2b_data0", tdat[0], 32'hA0A0_A0A0);
    chk("b2b_data1", tdat[1], 32'hB1B1_B1B1);
    @(negedge clk);

    // 4b: LATENCY=3, address changed during WAIT is ignored
    do_txn(1, 1'b1, 32'h40, 4'hF, 32'h1234_5678, rd, e, lat);
    chk("l3_wr_lat", lat, 32'd4);
    do_txn(1, 1'b1, 32'h44, 4'hF, 32'h9ABC_DEF0, rd, e, lat);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40;
    @(negedge clk);
    addr[1] = 32'h44;
    lat = 0; rd = '0;
    for (int c = 2; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (ack[1]) begin
        lat = c;
        rd  = rdata[1];
      end
    end
    req[1] = 1'b0;
    chk("l3_addr_chg_lat", lat, 32'd4);
    chk("l3_addr_chg_data", rd, 32'h1234_5678);
    @(negedge clk);

    // 5: reset during WAIT aborts a write
    do_txn(1, 1'b1, 32'h30, 4'hF, 32'h5, rd, e, lat);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h30; be[1] = 4'hF; wdata[1] = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("abort_in_wait", {30'b0, st[1]}, {30'b0, WAIT});
    rst = 1'b0;
    req[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_state", {30'b0, st[1]}, {30'b0, IDLE});
    acks_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack[1]) acks_seen++;
    end
    chk("abort_no_ack", acks_seen, 32'd0);
    do_txn(1, 1'b0, 32'h30, 4'h0, 32'h0, rd, e, lat);
    chk("abort_rd30", rd, 32'h5);

`ifdef BUS_RESPONDER_STATS_EN
    // 6: counters on the LATENCY=2 instance, zeroed by the reset above
    chk("stats_rst_rd", rdc[2], 32'd0);
    do_txn(2, 1'b0, 32'h10, 4'h0, 32'h0, rd, e, lat);
    do_txn(2, 1'b1, 32'h50, 4'hF, 32'h1, rd, e, lat);
    do_txn(2, 1'b0, 32'h20, 4'h0, 32'h0, rd, e, lat);
    do_txn(2, 1'b0, 32'h2, 4'h0, 32'h0, rd, e, lat);
    do_txn(2, 1'b1, 32'h54, 4'h3, 32'h2, rd, e, lat);
    do_txn(2, 1'b0, 32'h50, 4'h0, 32'h0, rd, e, lat);
    chk("stats_rd", rdc[2], 32'd3);
    chk("stats_wr", wrc[2], 32'd2);
    chk("stats_err", {16'b0, erc[2]}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
